// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch front end with a small prefetch buffer.
//
// Issues sequential word fetches from a PC register, tracks responses still
// owed by memory, buffers returned words together with their addresses and
// presents the oldest one to decode. A branch flushes the buffer and
// redirects the PC. Responses still owed at that point are counted down and
// discarded as they arrive.
//
// Parameters
//   BOOT_ADDR   first fetch address after reset
//   FIFO_DEPTH  prefetch buffer entries (2..4)
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   instr_req_o / instr_addr_o   fetch request and word address (= PC)
//   instr_gnt_i                  memory accepts the current request
//   instr_rvalid_i/instr_rdata_i read response, in request order
//   branch_i / branch_target_i   one-cycle redirect from execute
//   stall_i                      decode cannot accept this cycle
//   fetch_valid_o/_rdata_o/_addr_o  head of the prefetch buffer
//   misalign_o                   misaligned branch target flag
//
// Optional feature macro: MILANO_FETCH_ALIGN_CHECK_EN
//   defined   : a branch with target[1:0] != 0 is ignored and misalign_o
//               pulses for one cycle
//   undefined : target[1:0] is forced to zero and misalign_o is tied low
module instr_fetch #(
   parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        instr_req_o,
   output logic [31:0] instr_addr_o,
   input  logic        instr_gnt_i,
   input  logic        instr_rvalid_i,
   input  logic [31:0] instr_rdata_i,
   input  logic        branch_i,
   input  logic [31:0] branch_target_i,
   input  logic        stall_i,
   output logic        fetch_valid_o,
   output logic [31:0] fetch_rdata_o,
   output logic [31:0] fetch_addr_o,
   output logic        misalign_o
);

   localparam int PW = (FIFO_DEPTH > 2) ? 2 : 1;

   logic [31:0]   pc_q, pc_d;
   logic [31:0]   rsp_pc_q, rsp_pc_d;
   logic [31:0]   redir_addr_q, redir_addr_d;
   logic          redir_q, redir_d;
   logic          held_q, held_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [2:0]    os_q, os_d;
   logic [7:0]    drop_q, drop_d;
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [31:0]   buf_addr_q [FIFO_DEPTH];
   logic [31:0]   buf_data_q [FIFO_DEPTH];

   logic          branch_eff;
   logic [31:0]   target_eff;
   logic [3:0]    in_flight;
   logic          hs, rsp_live, rsp_drop, rsp_take, push, pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

`ifdef MILANO_FETCH_ALIGN_CHECK_EN
   logic misalign_q, misalign_d;
   always_comb begin
      branch_eff = branch_i && (branch_target_i[1:0] == 2'b00);
      target_eff = branch_target_i;
      misalign_d = branch_i && (branch_target_i[1:0] != 2'b00);
   end
   assign misalign_o = misalign_q;
`else
   always_comb begin
      branch_eff = branch_i;
      target_eff = branch_target_i & ~32'h3;
   end
   assign misalign_o = 1'b0;
`endif

   // A held request stays up through a branch; otherwise a new request needs
   // room for its response in the buffer.
   assign in_flight    = {1'b0, cnt_q} + {1'b0, os_q};
   assign instr_req_o  = !rst_i && (held_q || (in_flight < 4'(FIFO_DEPTH) && !branch_eff));
   assign instr_addr_o = pc_q;

   assign hs       = instr_req_o && instr_gnt_i;
   assign rsp_drop = instr_rvalid_i && (drop_q != 8'd0);
   assign rsp_take = instr_rvalid_i && (drop_q == 8'd0) && (os_q != 3'd0);
   assign rsp_live = rsp_drop || rsp_take;
   assign pop      = (cnt_q != 3'd0) && !stall_i && !branch_eff;
   assign push     = rsp_take && !branch_eff && (cnt_q < 3'(FIFO_DEPTH) || pop);

   assign fetch_valid_o = (cnt_q != 3'd0);
   assign fetch_rdata_o = fetch_valid_o ? buf_data_q[rd_q] : 32'h0;
   assign fetch_addr_o  = fetch_valid_o ? buf_addr_q[rd_q] : 32'h0;

   always_comb begin
      pc_d         = pc_q;
      rsp_pc_d     = rsp_pc_q;
      redir_addr_d = redir_addr_q;
      redir_d      = redir_q;
      held_d       = instr_req_o && !instr_gnt_i;
      cnt_d        = cnt_q;
      os_d         = os_q;
      drop_d       = drop_q;
      rd_d         = rd_q;
      wr_d         = wr_q;
      if (branch_eff) begin
         // Everything owed by memory, including a handshake completing now,
         // becomes a discard; a beat arriving this cycle settles one of them.
         cnt_d    = 3'd0;
         rd_d     = '0;
         wr_d     = '0;
         os_d     = 3'd0;
         drop_d   = drop_q + 8'(os_q) + 8'(hs) - 8'(rsp_live);
         rsp_pc_d = target_eff;
         if (held_q && !instr_gnt_i) begin
            // Keep the stalled request at its old address; redirect after it.
            redir_d      = 1'b1;
            redir_addr_d = target_eff;
         end else begin
            redir_d = 1'b0;
            pc_d    = target_eff;
         end
      end else begin
         drop_d = drop_q + 8'(hs && redir_q) - 8'(rsp_drop);
         os_d   = os_q + 3'(hs && !redir_q) - 3'(rsp_take);
         if (hs) begin
            pc_d    = redir_q ? redir_addr_q : pc_q + 32'd4;
            redir_d = 1'b0;
         end
         if (push) begin
            wr_d     = ptr_inc(wr_q);
            rsp_pc_d = rsp_pc_q + 32'd4;
         end
         if (pop) rd_d = ptr_inc(rd_q);
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = cnt_q - 3'd1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q         <= BOOT_ADDR;
         rsp_pc_q     <= BOOT_ADDR;
         redir_addr_q <= 32'h0;
         redir_q      <= 1'b0;
         held_q       <= 1'b0;
         cnt_q        <= 3'd0;
         os_q         <= 3'd0;
         drop_q       <= 8'd0;
         rd_q         <= '0;
         wr_q         <= '0;
`ifdef MILANO_FETCH_ALIGN_CHECK_EN
         misalign_q   <= 1'b0;
`endif
      end else begin
         pc_q         <= pc_d;
         rsp_pc_q     <= rsp_pc_d;
         redir_addr_q <= redir_addr_d;
         redir_q      <= redir_d;
         held_q       <= held_d;
         cnt_q        <= cnt_d;
         os_q         <= os_d;
         drop_q       <= drop_d;
         rd_q         <= rd_d;
         wr_q         <= wr_d;
`ifdef MILANO_FETCH_ALIGN_CHECK_EN
         misalign_q   <= misalign_d;
`endif
      end
   end

   // Buffer storage needs no reset: outputs are masked while it is empty.
   always_ff @(posedge clk_i) begin
      if (!rst_i && push) begin
         buf_addr_q[wr_q] <= rsp_pc_q;
         buf_data_q[wr_q] <= instr_rdata_i;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        instr_req_o;
   logic [31:0] instr_addr_o;
   logic        instr_gnt_i;
   logic        instr_rvalid_i;
   logic [31:0] instr_rdata_i;
   logic        branch_i;
   logic [31:0] branch_target_i;
   logic        stall_i;
   logic        fetch_valid_o;
   logic [31:0] fetch_rdata_o;
   logic [31:0] fetch_addr_o;
   logic        misalign_o;

   int          n_chk = 0;
   int          n_bad = 0;
   int          n_cons = 0;
   logic [31:0] exp_next = 32'h0;
   logic        mon_en = 1'b0;
   logic        br_kill = 1'b0;
   logic        mem_hold = 1'b0;
   logic [31:0] mem_q [$];

   always #5 clk_i = ~clk_i;

   instr_fetch #(.BOOT_ADDR(32'h0), .FIFO_DEPTH(2)) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .instr_req_o     (instr_req_o),
      .instr_addr_o    (instr_addr_o),
      .instr_gnt_i     (instr_gnt_i),
      .instr_rvalid_i  (instr_rvalid_i),
      .instr_rdata_i   (instr_rdata_i),
      .branch_i        (branch_i),
      .branch_target_i (branch_target_i),
      .stall_i         (stall_i),
      .fetch_valid_o   (fetch_valid_o),
      .fetch_rdata_o   (fetch_rdata_o),
      .fetch_addr_o    (fetch_addr_o),
      .misalign_o      (misalign_o)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'd2654435761) ^ 32'h5A5A_A5A5;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Memory: handshake seen in cycle k answers in cycle k+1 unless held.
   initial begin
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = 32'h0;
      forever begin
         @(negedge clk_i);
         if (instr_req_o && instr_gnt_i) mem_q.push_back(instr_addr_o);
         @(posedge clk_i);
         #1;
         if (mem_q.size() > 0 && !mem_hold) begin
            instr_rvalid_i = 1'b1;
            instr_rdata_i  = mem_word(mem_q.pop_front());
         end else begin
            instr_rvalid_i = 1'b0;
            instr_rdata_i  = 32'hDEAD_BEEF;
         end
      end
   end

   // Consumer: every instruction accepted by decode must be the next one.
   initial begin
      forever begin
         @(negedge clk_i);
         if (mon_en && fetch_valid_o && !stall_i && !br_kill) begin
            chk("cons_addr", fetch_addr_o, exp_next);
            chk("cons_rdata", fetch_rdata_o, mem_word(exp_next));
            exp_next = exp_next + 32'd4;
            n_cons++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", n_chk, n_bad);
      $fatal(1);
   end

   initial begin
      logic [31:0] x;
      int          n0;
      bit          seen;
      rst_i = 1'b1; instr_gnt_i = 1'b0; branch_i = 1'b0;
      branch_target_i = 32'h0; stall_i = 1'b0;

      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_req", instr_req_o, 0);
      chk("rst_iaddr", instr_addr_o, 32'h0);
      chk("rst_valid", fetch_valid_o, 0);
      chk("rst_rdata", fetch_rdata_o, 32'h0);
      chk("rst_faddr", fetch_addr_o, 32'h0);
      chk("rst_misalign", misalign_o, 0);

      tick();
      rst_i = 1'b0; instr_gnt_i = 1'b1; mon_en = 1'b1;
      @(negedge clk_i);
      chk("first_req", instr_req_o, 1);
      chk("first_iaddr", instr_addr_o, 32'h0);
      chk("valid_c0", fetch_valid_o, 0);
      @(negedge clk_i);
      chk("valid_c1", fetch_valid_o, 0);
      @(negedge clk_i);
      chk("valid_c2", fetch_valid_o, 1);
      chk("first_faddr", fetch_addr_o, 32'h0);
      chk("first_rdata", fetch_rdata_o, mem_word(32'h0));
      repeat (20) @(negedge clk_i);

      // Decode stall: buffer fills to two entries and requests stop.
      tick(); stall_i = 1'b1;
      repeat (10) @(negedge clk_i);
      chk("stall_req", instr_req_o, 0);
      chk("stall_valid", fetch_valid_o, 1);
      chk("stall_head", fetch_addr_o, exp_next);
      tick(); stall_i = 1'b0;
      repeat (10) @(negedge clk_i);

      // Grant withheld: request and address must hold.
      tick(); instr_gnt_i = 1'b0;
      repeat (5) @(negedge clk_i);
      x = exp_next;
      for (int i = 0; i < 3; i++) begin
         chk("gnt_low_req", instr_req_o, 1);
         chk("gnt_low_addr", instr_addr_o, x);
         @(negedge clk_i);
      end
      tick(); instr_gnt_i = 1'b1;
      @(negedge clk_i);
      chk("gnt_cycle_addr", instr_addr_o, x);
      tick(); instr_gnt_i = 1'b0;
      @(negedge clk_i);
      chk("gnt_after_addr", instr_addr_o, x + 32'd4);
      tick(); instr_gnt_i = 1'b1;
      repeat (10) @(negedge clk_i);

      // Branch with two responses owed.
      mem_hold = 1'b1;
      repeat (8) @(negedge clk_i);
      chk("br_pre_req", instr_req_o, 0);
      chk("br_pre_valid", fetch_valid_o, 0);
      chk("br_pre_owed", mem_q.size(), 2);
      tick();
      branch_i = 1'b1; branch_target_i = 32'h100; br_kill = 1'b1; exp_next = 32'h100;
      tick();
      branch_i = 1'b0; br_kill = 1'b0;
      @(negedge clk_i);
      chk("br_valid_low", fetch_valid_o, 0);
      mem_hold = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk_i);
         if (fetch_valid_o) seen = 1'b1;
      end
      chk("br_seen", seen, 1);
      chk("br_faddr", fetch_addr_o, 32'h100);
      chk("br_rdata", fetch_rdata_o, mem_word(32'h100));
      repeat (10) @(negedge clk_i);

      // Misaligned branch target.
      tick();
      branch_i = 1'b1; branch_target_i = 32'h102;
`ifdef MILANO_FETCH_ALIGN_CHECK_EN
      br_kill = 1'b0;
`else
      br_kill = 1'b1; exp_next = 32'h100;
`endif
      tick();
      branch_i = 1'b0; br_kill = 1'b0;
      @(negedge clk_i);
`ifdef MILANO_FETCH_ALIGN_CHECK_EN
      chk("misalign_pulse", misalign_o, 1);
`else
      chk("misalign_pulse", misalign_o, 0);
`endif
      @(negedge clk_i);
      chk("misalign_clear", misalign_o, 0);
      n0 = n_cons;
      repeat (20) @(negedge clk_i);
      chk("mis_progress", (n_cons - n0) >= 5, 1);
      chk("total_cons", n_cons >= 30, 1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
